// File: rtl/asip_pkg.sv
// Shared definitions for the ASIP front end: fetch FSM states and the
// instruction type field used to recognise HALT-type instructions.
package asip_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  // Instruction type field occupies [TYPE_MSB:TYPE_MSB-1]
  localparam int unsigned TYPE_MSB  = 16;
  localparam logic [1:0]  TYPE_HALT = 2'b11;

endpackage : asip_pkg

// File: rtl/pc_reg.sv
// Program counter register: sequential increment with modulo-2^PC_W wrap,
// or a redirect load, both only on enabled cycles.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pc <= RESET_PC)
//   en          - advance/load this cycle, otherwise hold
//   load        - take target instead of pc+1
//   target      - redirect address
//   pc          - current program counter
module pc_reg #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= load ? target : pc + PC_W'(1);
    end
  end

endmodule : pc_reg

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a one-cycle-latency instruction memory,
// tracks the address of the returned word, squashes the wrong-path word
// after a taken branch and stops fetching on a HALT-type instruction.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   stall                        - downstream not accepting; freeze all state
//   branch_taken, branch_target  - redirect request and word address
//   imem_addr, imem_en           - memory read address / enable
//   imem_rdata                   - memory read data (one cycle after addr/en)
//   instr, instr_valid, instr_pc - instruction to the core, valid flag, address
//   halted                       - fetch stopped by a HALT-type instruction
module fetch_unit
  import asip_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 24,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fpc_q;
  logic            pending_q;
  logic            squash_q;
  logic            fetch_en;
  logic            branch_acc;
  logic            halt_hit;

  assign fetch_en    = !stall && (state_q != S_HALT);
  assign instr_valid = pending_q && !squash_q && (state_q == S_RUN);
  // A branch only counts when it comes from a real, accepted instruction
  assign branch_acc  = branch_taken && !stall && instr_valid;
  // Branch beats halt when both are present on the same instruction
  assign halt_hit    = instr_valid && !stall && !branch_taken &&
                       (imem_rdata[TYPE_MSB -: 2] == TYPE_HALT);

  assign imem_addr = pc_q;
  assign imem_en   = fetch_en;
  assign instr     = imem_rdata;
  assign instr_pc  = fpc_q;
  assign halted    = (state_q == S_HALT);

  pc_reg #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (fetch_en),
    .load  (branch_acc),
    .target(branch_target),
    .pc    (pc_q)
  );

  // Fetch-side tracking of the in-flight word: its address, presence, and
  // whether it is the wrong-path word following a redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= '0;
      pending_q <= 1'b0;
      squash_q  <= 1'b0;
    end else if (fetch_en) begin
      fpc_q     <= pc_q;
      pending_q <= 1'b1;
      squash_q  <= branch_acc;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: if (!stall) state_d = S_RUN;
      S_RUN:   if (halt_hit) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory
// model whose word encodes its own address and a selectable HALT type.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [23:0] imem_rdata;
  logic [23:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic        halt_on   = 1'b0;
  logic [15:0] halt_addr = 16'h0000;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] word(input logic [15:0] a);
    logic [1:0] t;
    t = (halt_on && a == halt_addr) ? 2'b11 : 2'b00;
    return {7'h00, t, a[14:0]};
  endfunction

  // Memory holds its read data while disabled
  initial imem_rdata = 24'h0;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= word(imem_addr);
  end

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Valid instruction at address a, with its memory word
  task automatic ck_instr(input string tag, input logic [15:0] a);
    ck({tag, "_valid"}, 32'(instr_valid), 32'd1);
    ck({tag, "_pc"}, 32'(instr_pc), 32'(a));
    ck({tag, "_instr"}, 32'(instr), 32'(word(a)));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    cyc(); cyc();
    ck("rst_valid", 32'(instr_valid), 32'd0);
    ck("rst_pc", 32'(instr_pc), 32'd0);
    ck("rst_halted", 32'(halted), 32'd0);
    ck("rst_addr", 32'(imem_addr), 32'd0);
    ck("rst_en", 32'(imem_en), 32'd1);
    stall = 1'b1; #1;
    ck("rst_en_stall", 32'(imem_en), 32'd0);
    stall = 1'b0;
    reset = 1'b0; #1;
    ck("start_addr", 32'(imem_addr), 32'd0);
    ck("start_valid", 32'(instr_valid), 32'd0);

    // Sequential fetch from 0
    cyc(); ck_instr("seq0", 16'h0000);
    cyc(); ck_instr("seq1", 16'h0001);
    cyc(); ck_instr("seq2", 16'h0002);
    cyc(); ck_instr("seq3", 16'h0003);
    cyc(); cyc(); ck_instr("seq5", 16'h0005);

    // Branch at 0x0005 to 0x0040: one bubble
    branch_taken = 1'b1; branch_target = 16'h0040;
    cyc(); branch_taken = 1'b0;
    ck("br_bubble", 32'(instr_valid), 32'd0);
    cyc(); ck_instr("br40", 16'h0040);
    cyc(); ck_instr("br41", 16'h0041);

    // Redirect to 0x0007
    branch_taken = 1'b1; branch_target = 16'h0007;
    cyc(); branch_taken = 1'b0;
    ck("br7_bubble", 32'(instr_valid), 32'd0);
    cyc(); ck_instr("br7", 16'h0007);

    // Stall three cycles at 0x0007 with a branch request that must be ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h1234; #1;
    ck("stall_en", 32'(imem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      ck("stall_en_hold", 32'(imem_en), 32'd0);
      ck_instr("stall_hold", 16'h0007);
    end
    stall = 1'b0; branch_taken = 1'b0;
    cyc(); ck_instr("stall_rel", 16'h0008);

    // Wrap: redirect to 0xFFFE then run through 0xFFFF -> 0x0000
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    cyc(); branch_taken = 1'b0;
    ck("wr_bubble", 32'(instr_valid), 32'd0);
    cyc(); ck_instr("wrFFFE", 16'hFFFE);
    cyc(); ck_instr("wrFFFF", 16'hFFFF);
    cyc(); ck_instr("wr0000", 16'h0000);

    // HALT-type at 0x0002 together with a branch: branch wins
    halt_on = 1'b1; halt_addr = 16'h0002;
    cyc(); ck_instr("hb1", 16'h0001);
    cyc(); ck_instr("hb2", 16'h0002);
    branch_taken = 1'b1; branch_target = 16'h0010;
    cyc(); branch_taken = 1'b0;
    ck("hb_bubble", 32'(instr_valid), 32'd0);
    ck("hb_halted", 32'(halted), 32'd0);
    cyc(); ck_instr("hb10", 16'h0010);
    ck("hb10_halted", 32'(halted), 32'd0);

    // HALT-type at 0x0003
    halt_addr = 16'h0003;
    branch_taken = 1'b1; branch_target = 16'h0003;
    cyc(); branch_taken = 1'b0;
    ck("h_bubble", 32'(instr_valid), 32'd0);
    cyc(); ck_instr("h3", 16'h0003);
    ck("h3_halted", 32'(halted), 32'd0);
    cyc();
    ck("h_halted", 32'(halted), 32'd1);
    ck("h_valid", 32'(instr_valid), 32'd0);
    ck("h_en", 32'(imem_en), 32'd0);
    ck("h_addr", 32'(imem_addr), 32'h0005);
    branch_taken = 1'b1; branch_target = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      cyc();
      ck("h_stay_halted", 32'(halted), 32'd1);
      ck("h_stay_valid", 32'(instr_valid), 32'd0);
      ck("h_stay_addr", 32'(imem_addr), 32'h0005);
    end
    branch_taken = 1'b0;

    // Reset out of HALT
    reset = 1'b1;
    cyc();
    ck("hr_halted", 32'(halted), 32'd0);
    ck("hr_valid", 32'(instr_valid), 32'd0);
    ck("hr_pc", 32'(instr_pc), 32'd0);
    ck("hr_addr", 32'(imem_addr), 32'd0);
    ck("hr_en", 32'(imem_en), 32'd1);
    reset = 1'b0;
    cyc(); ck_instr("hr0", 16'h0000);
    cyc(); ck_instr("hr1", 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
